// File: rtl/vector_fb_arbiter.sv
// Single-port framebuffer scheduler: CPU byte access (highest priority), line-drawer
// pixel writes and a whole-buffer clear/fade sequencer sharing RAM port B.
module vector_fb_arbiter #(
    parameter int FADE_SHIFT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vblank,
    input  logic        auto_clear,
    input  logic        clear_start,
    input  logic        clear_mode,
    output logic        clear_busy,
    output logic        clear_done,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    input  logic        draw_req,
    input  logic [7:0]  draw_x,
    input  logic [7:0]  draw_y,
    input  logic [7:0]  draw_data,
    output logic        draw_ack,
    output logic [15:0] fb_addr,
    output logic        fb_we,
    output logic [7:0]  fb_din,
    input  logic [7:0]  fb_dout
);
    typedef enum logic [1:0] {IDLE, CPU_RD, FADE_WAIT, FADE_WR} state_t;

    localparam logic WIN_CLEAR = 1'b0;
    localparam logic WIN_DRAW  = 1'b1;

    state_t      state, state_d;
    logic        last_winner, last_winner_d;
    logic [15:0] clr_addr, clr_addr_d;
    logic        clr_mode, clr_mode_d;
    logic        busy_d, done_d, cpu_ack_d, draw_ack_d;
    logic        rd_ack, rd_ack_d;
    logic        fb_we_d;
    logic [15:0] fb_addr_d;
    logic [7:0]  fb_din_d;
    logic [7:0]  rd_hold;
    logic        vblank_q;
    logic        cpu_pend, draw_pend, start, draw_wins, last_pixel;
    logic [7:0]  fade_val;

    assign cpu_pend   = cpu_req && !cpu_ack;
    assign draw_pend  = draw_req && !draw_ack;
    assign start      = (clear_start || (auto_clear && vblank && !vblank_q)) && !clear_busy;
    assign draw_wins  = draw_pend && (!clear_busy || last_winner == WIN_CLEAR);
    assign last_pixel = (clr_addr == 16'hFFFF);
    assign fade_val   = fb_dout >> FADE_SHIFT;

    // RAM data arrives in the ack cycle itself, so it is forwarded while cpu_ack is
    // high and held afterwards; this keeps the read at two cycles from request.
    assign cpu_dout = rd_ack ? fb_dout : rd_hold;

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d       = state;
        last_winner_d = last_winner;
        clr_addr_d    = clr_addr;
        clr_mode_d    = clr_mode;
        busy_d        = clear_busy;
        done_d        = 1'b0;
        cpu_ack_d     = 1'b0;
        draw_ack_d    = 1'b0;
        rd_ack_d      = 1'b0;
        fb_we_d       = 1'b0;
        fb_addr_d     = fb_addr;
        fb_din_d      = fb_din;

        if (start) begin
            busy_d     = 1'b1;
            clr_addr_d = 16'h0000;
            clr_mode_d = clear_mode;
        end

        case (state)
            IDLE: begin
                if (cpu_pend) begin
                    fb_addr_d = cpu_addr;
                    if (cpu_we) begin
                        fb_we_d   = 1'b1;
                        fb_din_d  = cpu_din;
                        cpu_ack_d = 1'b1;
                    end else begin
                        state_d = CPU_RD;
                    end
                end else if (draw_wins) begin
                    fb_addr_d     = {draw_y, draw_x};
                    fb_din_d      = draw_data;
                    fb_we_d       = 1'b1;
                    draw_ack_d    = 1'b1;
                    last_winner_d = WIN_DRAW;
                end else if (clear_busy) begin
                    fb_addr_d     = clr_addr;
                    last_winner_d = WIN_CLEAR;
                    if (clr_mode) begin
                        state_d = FADE_WAIT;
                    end else begin
                        fb_we_d    = 1'b1;
                        fb_din_d   = 8'h00;
                        clr_addr_d = clr_addr + 16'd1;
                        if (last_pixel) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            CPU_RD: begin
                cpu_ack_d = 1'b1;
                rd_ack_d  = 1'b1;
                state_d   = IDLE;
            end
            FADE_WAIT: state_d = FADE_WR;
            FADE_WR: begin
                // fb_addr still holds the pixel read two cycles ago.
                fb_we_d    = 1'b1;
                fb_din_d   = fade_val;
                clr_addr_d = clr_addr + 16'd1;
                state_d    = IDLE;
                if (last_pixel) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state       <= IDLE;
            last_winner <= WIN_CLEAR;
            clr_addr    <= 16'h0000;
            clr_mode    <= 1'b0;
            clear_busy  <= 1'b0;
            clear_done  <= 1'b0;
            cpu_ack     <= 1'b0;
            draw_ack    <= 1'b0;
            rd_ack      <= 1'b0;
            rd_hold     <= 8'h00;
            fb_we       <= 1'b0;
            fb_addr     <= 16'h0000;
            fb_din      <= 8'h00;
            vblank_q    <= 1'b0;
        end else begin
            state       <= state_d;
            last_winner <= last_winner_d;
            clr_addr    <= clr_addr_d;
            clr_mode    <= clr_mode_d;
            clear_busy  <= busy_d;
            clear_done  <= done_d;
            cpu_ack     <= cpu_ack_d;
            draw_ack    <= draw_ack_d;
            rd_ack      <= rd_ack_d;
            if (rd_ack) rd_hold <= fb_dout;
            fb_we       <= fb_we_d;
            fb_addr     <= fb_addr_d;
            fb_din      <= fb_din_d;
            vblank_q    <= vblank;
        end
    end
endmodule

// File: tb/tb_vector_fb_arbiter.sv
// Bench for vector_fb_arbiter: a behavioural RAM on port B plus a shadow image of the
// framebuffer that the bench updates from the access rules of each request it issues.
module tb_vector_fb_arbiter;
    logic        clk = 1'b0;
    logic        reset, vblank, auto_clear, clear_start, clear_mode;
    logic        clear_busy, clear_done;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din, cpu_dout;
    logic        cpu_ack;
    logic        draw_req;
    logic [7:0]  draw_x, draw_y, draw_data;
    logic        draw_ack;
    logic [15:0] fb_addr;
    logic        fb_we;
    logic [7:0]  fb_din, fb_dout;

    always #5 clk = ~clk;

    vector_fb_arbiter #(.FADE_SHIFT(1)) dut (
        .clk(clk), .reset(reset), .vblank(vblank), .auto_clear(auto_clear),
        .clear_start(clear_start), .clear_mode(clear_mode),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y), .draw_data(draw_data),
        .draw_ack(draw_ack),
        .fb_addr(fb_addr), .fb_we(fb_we), .fb_din(fb_din), .fb_dout(fb_dout)
    );

    // Framebuffer RAM with one-cycle read latency; preload fills the whole array.
    logic [7:0] ram [65536];
    logic       preload = 1'b0;
    logic [7:0] preload_val = 8'h00;

    always @(posedge clk) begin
        fb_dout <= ram[fb_addr];
        if (preload) begin
            for (int i = 0; i < 65536; i++) ram[i] <= preload_val;
        end else if (fb_we) begin
            ram[fb_addr] <= fb_din;
        end
    end

    int we_count = 0;
    always @(negedge clk) if (fb_we) we_count++;

    logic [7:0] expect_mem [65536];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d,
                          input int lat);
        int n;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
        n = 0;
        do begin step(); n++; end while (!cpu_ack && n < 16);
        check(we ? "cpu_wr_lat" : "cpu_rd_lat", 32'(n), 32'(lat));
        if (we) begin
            check("cpu_wr_port", {7'd0, fb_we, fb_addr, fb_din}, {7'd0, 1'b1, a, d});
            expect_mem[a] = d;
        end else begin
            check("cpu_rd_data", 32'(cpu_dout), 32'(expect_mem[a]));
        end
        cpu_req = 1'b0;
        step();
    endtask

    task automatic draw_op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] d);
        int n;
        draw_req = 1'b1; draw_x = x; draw_y = y; draw_data = d;
        n = 0;
        do begin step(); n++; end while (!draw_ack && n < 16);
        check("draw_lat", 32'(n), 32'd1);
        check("draw_port", {7'd0, fb_we, fb_addr, fb_din}, {7'd0, 1'b1, y, x, d});
        expect_mem[{y, x}] = d;
        draw_req = 1'b0;
        step();
    endtask

    // Fade-pass observation state
    int          cyc, next_clear, last_ack;
    logic        last_was_draw;
    logic [15:0] p1_addr, p2_addr, cur_pix;
    logic        p1_we, p2_we;

    task automatic new_pixel();
        draw_x    = 8'($urandom_range(255, 0));
        draw_y    = 8'($urandom_range(255, 128));
        draw_data = 8'($urandom_range(255, 0));
        cur_pix   = {draw_y, draw_x};
    endtask

    task automatic fade_observe();
        step();
        cyc++;
        if (fb_we) begin
            if (fb_addr < 16'h8000) begin
                check("fade_order", 32'(fb_addr), 32'(next_clear));
                check("fade_value", 32'(fb_din), 32'h40);
                check("fade_lock_addr", {p2_addr, p1_addr}, {fb_addr, fb_addr});
                check("fade_lock_we", {30'd0, p2_we, p1_we}, 32'd0);
                check("alt_after_draw", 32'(last_was_draw), 32'd1);
                last_was_draw = 1'b0;
                next_clear++;
            end else begin
                check("alt_after_clear", 32'(last_was_draw), 32'd0);
                check("draw_addr", 32'(fb_addr), 32'(cur_pix));
                check("draw_data", 32'(fb_din), 32'(draw_data));
                last_was_draw = 1'b1;
            end
        end
        if (draw_ack) begin
            if (last_ack >= 0) check("draw_gap", 32'(cyc - last_ack), 32'd4);
            last_ack = cyc;
            expect_mem[cur_pix] = draw_data;
            new_pixel();
        end
        p2_addr = p1_addr; p2_we = p1_we;
        p1_addr = fb_addr; p1_we = fb_we;
    endtask

    initial begin
        int          w0, bad, n, busy_cycles, done_count, first_addr, tail_we, tail_busy;
        logic        found;
        logic [15:0] abort_addr;
        logic [15:0] a;
        logic [7:0]  d, x;

        reset = 1'b1; vblank = 1'b0; auto_clear = 1'b0; clear_start = 1'b0; clear_mode = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        draw_req = 1'b0; draw_x = '0; draw_y = '0; draw_data = '0;
        preload = 1'b1; preload_val = 8'h00;
        for (int i = 0; i < 65536; i++) expect_mem[i] = 8'h00;
        step(); step();
        preload = 1'b0;
        check("rst_port", {7'd0, fb_we, fb_addr, fb_din}, 32'd0);
        check("rst_ctrl", {24'd0, cpu_dout}, 32'd0);
        check("rst_flags", {28'd0, cpu_ack, draw_ack, clear_busy, clear_done}, 32'd0);
        reset = 1'b0;
        step();

        // CPU write then read back
        w0 = we_count;
        cpu_op(1'b1, 16'h1234, 8'h5A, 1);
        cpu_op(1'b0, 16'h1234, 8'h00, 2);
        check("single_we_pulse", 32'(we_count - w0), 32'd1);

        // CPU and drawer together: CPU first, drawer next cycle
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_din = 8'h11;
        draw_req = 1'b1; draw_x = 8'd3; draw_y = 8'd2; draw_data = 8'hFF;
        step();
        check("both_cpu_first", {30'd0, cpu_ack, draw_ack}, 32'b10);
        cpu_req = 1'b0;
        expect_mem[16'h0100] = 8'h11;
        step();
        check("both_draw_next", {7'd0, draw_ack, fb_addr, fb_din}, {7'd0, 1'b1, 16'h0203, 8'hFF});
        draw_req = 1'b0;
        expect_mem[16'h0203] = 8'hFF;
        step();
        check("ram_0203", 32'(ram[16'h0203]), 32'hFF);
        cpu_op(1'b0, 16'h0100, 8'h00, 2);

        // Random CPU / drawer traffic over a shared window
        for (int i = 0; i < 150; i++) begin
            a = {8'h04, 2'b00, 6'($urandom_range(63, 0))};
            x = {2'b00, 6'($urandom_range(63, 0))};
            d = 8'($urandom_range(255, 0));
            case ($urandom_range(2, 0))
                0:       cpu_op(1'b1, a, d, 1);
                1:       cpu_op(1'b0, a, 8'h00, 2);
                default: draw_op(x, 8'h04, d);
            endcase
        end

        // Fade pass over a 0x80 buffer, drawer held busy in the upper half
        reset = 1'b1; step(); reset = 1'b0;
        preload_val = 8'h80; preload = 1'b1; step(); preload = 1'b0;
        for (int i = 0; i < 65536; i++) expect_mem[i] = 8'h80;
        clear_mode = 1'b1; clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        check("fade_busy", 32'(clear_busy), 32'd1);
        cyc = 0; next_clear = 0; last_ack = -1; last_was_draw = 1'b0;
        p1_addr = fb_addr; p1_we = fb_we; p2_addr = fb_addr; p2_we = fb_we;
        new_pixel();
        draw_req = 1'b1;
        for (int i = 0; i < 400; i++) fade_observe();
        draw_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            fade_observe();
            if (!p1_we && p2_we && clear_busy) found = 1'b1;
        end
        check("fade_wait_found", 32'(found), 32'd1);

        // Reset while the fade read is in flight
        abort_addr = p1_addr;
        reset = 1'b1;
        step();
        check("abort_flags", {29'd0, fb_we, clear_busy, clear_done}, 32'd0);
        reset = 1'b0;
        check("abort_addr", 32'(abort_addr), 32'(next_clear));
        for (int i = 0; i < next_clear; i++) expect_mem[i] = 8'h40;
        step();
        bad = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] !== expect_mem[i]) bad++;
        check("fade_image", 32'(bad), 32'd0);

        // Mode 0 pass started by clear_start and a vblank edge together; a second edge mid-pass
        auto_clear = 1'b1; clear_mode = 1'b0; clear_start = 1'b1; vblank = 1'b1;
        step();
        clear_start = 1'b0;
        busy_cycles = 0; done_count = 0; first_addr = -1; n = 0;
        while (done_count == 0 && n < 70000) begin
            if (clear_busy) busy_cycles++;
            if (fb_we && first_addr < 0) first_addr = int'(fb_addr);
            if (n == 1000) vblank = 1'b0;
            if (n == 2000) vblank = 1'b1;
            step();
            n++;
            if (clear_done) done_count++;
        end
        check("pass_first_addr", 32'(first_addr), 32'd0);
        check("pass_last_write", {15'd0, fb_we, fb_addr}, {15'd0, 1'b1, 16'hFFFF});
        check("pass_busy_cycles", 32'(busy_cycles), 32'd65536);
        tail_we = 0; tail_busy = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (fb_we) tail_we++;
            if (clear_busy) tail_busy++;
            if (clear_done) done_count++;
        end
        check("pass_done_once", 32'(done_count), 32'd1);
        check("pass_no_continue", 32'(tail_we + tail_busy), 32'd0);
        auto_clear = 1'b0; vblank = 1'b0;
        for (int i = 0; i < 65536; i++) expect_mem[i] = 8'h00;
        bad = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] !== 8'h00) bad++;
        check("clear_image", 32'(bad), 32'd0);
        cpu_op(1'b0, 16'h1234, 8'h00, 2);
        cpu_op(1'b1, 16'hFFFF, 8'hC3, 1);
        cpu_op(1'b0, 16'hFFFF, 8'h00, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
